// File: rtl/serial_adder_fsm.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_fsm
// Brief    : Bit-serial two's-complement adder, one full-adder cell and a
//            carry flop, LSB first, parallel result with carry and overflow.
// Revision : 1.0
// ============================================================================
module serial_adder_fsm #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   ra_q;
    logic [WIDTH-1:0]   rb_q;
    logic [WIDTH-1:0]   sum_sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               sum_bit_d;
    logic               carry_d;
    logic [WIDTH-1:0]   sum_sr_d;

    // Single full-adder cell working on the current LSBs.
    assign sum_bit_d = ra_q[0] ^ rb_q[0] ^ carry_q;
    assign carry_d   = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);
    assign sum_sr_d  = {sum_bit_d, sum_sr_q[WIDTH-1:1]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            sum_sr_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        ra_q    <= A;
                        rb_q    <= B;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    ra_q     <= ra_q >> 1;
                    rb_q     <= rb_q >> 1;
                    sum_sr_q <= sum_sr_d;
                    carry_q  <= carry_d;
                    cnt_q    <= cnt_q + 1'b1;
                    // On the MSB step carry_q is the carry into the MSB.
                    if (cnt_q == C_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= sum_sr_d;
                        cout_q  <= carry_d;
                        ovf_q   <= carry_q ^ carry_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_fsm
// Brief    : Scoreboard bench for serial_adder_fsm (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_serial_adder_fsm;

    localparam int WIDTH = 8;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int push_cnt = 0;

    // Expected record: {Cout, Ovf, Sum}
    logic [WIDTH+1:0] sb_q[$];

    serial_adder_fsm #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 Clk = ~Clk;

    function automatic logic [WIDTH+1:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] full;
        logic           ov;
        full = {1'b0, a} + {1'b0, b};
        ov   = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {full[WIDTH], ov, full[WIDTH-1:0]};
    endfunction

    // Result monitor: every Done pulse must match the oldest pending operation.
    always @(negedge Clk) begin
        if (Done) begin
            logic [WIDTH+1:0] exp;
            done_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got sum=%h cout=%b ovf=%b, required no Done", Sum, Cout, Ovf);
            end else begin
                exp = sb_q.pop_front();
                if ({Cout, Ovf, Sum} !== exp) begin
                    failures++;
                    $display("FAIL result got cout=%b ovf=%b sum=%h, required cout=%b ovf=%b sum=%h",
                             Cout, Ovf, Sum, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
                end
            end
        end
    end

    // Drives a one-edge Start request; push=1 records the expected result.
    task automatic pulse_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        Start = 1'b1;
        A     = a;
        B     = b;
        if (push) begin
            sb_q.push_back(golden(a, b));
            push_cnt++;
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Done && n < 40);
        if (!Done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got no Done after %0d cycles, required Done", n);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge Clk);
            checks++;
            if ({Busy, Done, Sum, Cout, Ovf} !== '0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                         i, Busy, Done, Sum, Cout, Ovf);
            end
        end
    endtask

    task automatic test_basic();
        @(posedge Clk);
        #1;
        pulse_start(8'h35, 8'h1C, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            checks++;
            if (Busy !== 1'b1 || Done !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy cycle %0d got busy=%b done=%b, required busy=1 done=0", i, Busy, Done);
            end
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Sum !== 8'h51) begin
            failures++;
            $display("FAIL basic_done got done=%b busy=%b sum=%h, required done=1 busy=0 sum=51", Done, Busy, Sum);
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || Sum !== 8'h51) begin
            failures++;
            $display("FAIL basic_hold got done=%b sum=%h, required done=0 sum=51", Done, Sum);
        end
    endtask

    task automatic test_boundary();
        pulse_start(8'hFF, 8'h01, 1'b1);
        wait_done();
        pulse_start(8'h7F, 8'h01, 1'b1);
        wait_done();
        pulse_start(8'h80, 8'h80, 1'b1);
        wait_done();
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_ignore_start();
        pulse_start(8'h12, 8'h34, 1'b1);
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        pulse_start(8'hAA, 8'h55, 1'b0);
        wait_done();
        repeat (12) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Sum !== 8'h46) begin
            failures++;
            $display("FAIL ignore_start got busy=%b sum=%h, required busy=0 sum=46", Busy, Sum);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_start(8'h11, 8'h22, 1'b1);
        wait_done();
        pulse_start(8'hC3, 8'h5A, 1'b1);
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_no_gap got busy=%b, required busy=1", Busy);
        end
        n = 1;
        while (!Done && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n !== 9) begin
            failures++;
            $display("FAIL b2b_latency got %0d cycles to Done, required 9", n);
        end
    endtask

    task automatic test_abort();
        @(negedge Clk);
        pulse_start(8'h40, 8'h41, 1'b0);
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({Busy, Done, Sum, Cout, Ovf} !== '0) begin
            failures++;
            $display("FAIL abort_reset got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     Busy, Done, Sum, Cout, Ovf);
        end
        repeat (12) @(negedge Clk);
        pulse_start(8'h02, 8'h03, 1'b1);
        wait_done();
        checks++;
        if (Sum !== 8'h05) begin
            failures++;
            $display("FAIL abort_restart got sum=%h, required 05", Sum);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            pulse_start(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
        repeat (12) @(negedge Clk);
        checks++;
        if (done_cnt !== push_cnt || sb_q.size() !== 0) begin
            failures++;
            $display("FAIL done_count got %0d Done pulses (%0d pending), required %0d",
                     done_cnt, sb_q.size(), push_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
- Bit-serial WIDTH-bit adder: loads two operands, adds them LSB-first one bit per clock through a single full-adder cell and a carry flip-flop, and returns the parallel sum.
- Sits directly upstream of the team's D flip-flop stage: the carry register is that stage, instanced with the synchronous-reset behaviour defined below.
- Used as the datapath exercise for the sequential-circuits lab set.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset; sampled on the rising edge of Clk.
- Start  input  1  single-cycle request; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A, two's complement; captured when Start is accepted.
- B  input  WIDTH  operand B, two's complement; captured when Start is accepted.
- Busy  output  1  high while an addition is in progress (SHIFT state).
- Done  output  1  one-cycle pulse; Sum, Cout and Ovf are valid in this cycle.
- Sum  output  WIDTH  result; holds its value until the next accepted Start completes.
- Cout  output  1  carry out of the MSB.
- Ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset is synchronous and active-high: on a Clk edge with Reset=1, the block enters IDLE.
- Reset values: state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, Ovf=0, carry=0, counter=0, shift registers=0.
- Reset has priority over Start. Reset asserted mid-operation aborts the operation; no Done is generated.
- States: IDLE, SHIFT, DONE (2-bit encoding, one registered state variable).
- IDLE:
  - Start=1 at edge k loads A into ra and B into rb.
  - The same edge clears carry and counter and moves to SHIFT.
  - Start=0 stays in IDLE.
- SHIFT, on each edge:
  - s = ra[0]^rb[0]^carry.
  - carry <= majority(ra[0], rb[0], carry).
  - ra and rb shift right by one.
  - The sum shift register shifts right with s entering at the MSB.
  - counter increments.
  - On the edge where counter==WIDTH-1 (the WIDTH-th shift), the block moves to DONE.
  - At that same edge: Sum <= final shift-register contents, Cout <= final carry, Ovf <= (carry before MSB) ^ (carry after MSB).
- Latency and timing:
  - Start accepted at edge k gives Busy=1 for the cycles following edges k..k+WIDTH-1.
  - Done=1 for exactly the one cycle following edge k+WIDTH. Total latency is WIDTH edges.
- DONE:
  - Lasts exactly one cycle, then moves to IDLE.
  - Start=1 in DONE is accepted like in IDLE (back-to-back operation); the next state is SHIFT and the new operands are loaded.
- Start is ignored while in SHIFT. A and B may change freely after acceptance.
- Sum, Cout and Ovf change only at the DONE-entry edge or on reset; they are never partial mid-operation.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
1. Reset=1 for 2 cycles, then release -> Busy=0, Done=0, Sum=0x00, Cout=0, Ovf=0. With Start=0, the outputs stay put for 20 cycles.
2. WIDTH=8, A=0x35, B=0x1C, Start pulse at edge k -> Busy=1 for 8 cycles; Done=1 exactly one cycle after edge k+8 with Sum=0x51, Cout=0, Ovf=0.
3. A=0xFF, B=0x01 -> Sum=0x00, Cout=1, Ovf=0. A=0x7F, B=0x01 -> Sum=0x80, Cout=0, Ovf=1. A=0x80, B=0x80 -> Sum=0x00, Cout=1, Ovf=1.
4. Start re-pulsed with different A/B at cycle 3 of SHIFT -> ignored; result matches the first operands. Start held high in the DONE cycle -> second operation begins with no idle gap, and its Done appears 8 edges later.
5. Reset asserted at cycle 4 of SHIFT -> IDLE on the next edge, no Done pulse, Sum returns to 0x00. A following Start with A=0x02, B=0x03 -> Sum=0x05.
6. Randomised regression, 500 operations, with golden model {Cout,Sum}=A+B and Ovf from the sign bits -> zero mismatches; Done count equals the count of accepted Starts.
